// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO page for the 6502 system bus.
// Per-bit direction, atomic set/clear/toggle writes, multi-stage input
// synchronisers and registered read data (valid one cycle after rs).
// Optional build macro GPIO_IRQ_EN adds per-bit edge-detect interrupts
// (IEN/IFLG/EDGE registers and the irq output). Without it, rs=2,3,4
// read 0 and ignore writes, and irq is tied low.
module gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             we,
  input  logic [2:0]       rs,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] RS_DATA = 3'd0;
  localparam logic [2:0] RS_DIR  = 3'd1;
  localparam logic [2:0] RS_IEN  = 3'd2;
  localparam logic [2:0] RS_IFLG = 3'd3;
  localparam logic [2:0] RS_EDGE = 3'd4;
  localparam logic [2:0] RS_SET  = 3'd5;
  localparam logic [2:0] RS_CLR  = 3'd6;
  localparam logic [2:0] RS_TGL  = 3'd7;

  logic             wr;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] ien_rd;
  logic [WIDTH-1:0] iflg_rd;
  logic [WIDTH-1:0] edge_rd;
  logic [WIDTH-1:0] rd_w;
  logic [7:0]       rd_byte;

  assign wr   = cs & we;
  assign wdat = din[WIDTH-1:0];
  assign sync = sync_q[SYNC_STAGES-1];

  // Next output data: plain load or atomic set/clear/toggle.
  always_comb begin
    data_next = gpio_o;
    if (wr) begin
      case (rs)
        RS_DATA: data_next = wdat;
        RS_SET:  data_next = gpio_o | wdat;
        RS_CLR:  data_next = gpio_o & ~wdat;
        RS_TGL:  data_next = gpio_o ^ wdat;
        default: data_next = gpio_o;
      endcase
    end
  end

  // Output data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) gpio_o <= '0;
    else       gpio_o <= data_next;
  end

  // Direction register; a 1 bit drives the pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    gpio_oe <= '0;
    else if (wr && rs == RS_DIR)  gpio_oe <= wdat;
  end

  // Input synchroniser chain; the last stage is the usable pin value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] ien_q;
  logic [WIDTH-1:0] iflg_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr_mask;

  // Edge seen on input bits only; EDGE picks rising (0) or falling (1).
  assign det = ~gpio_oe & ((~edge_q & ~prev_q & sync) | (edge_q & prev_q & ~sync));
  assign clr_mask = (wr && rs == RS_IFLG) ? wdat : '0;

  // History flop holding the previous synchronised value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= '0;
    else       prev_q <= sync;
  end

  // Interrupt enable and edge polarity registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ien_q  <= '0;
      edge_q <= '0;
    end else if (wr) begin
      if (rs == RS_IEN)  ien_q  <= wdat;
      if (rs == RS_EDGE) edge_q <= wdat;
    end
  end

  // Flags: write-1-to-clear, but a new edge in the same cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) iflg_q <= '0;
    else       iflg_q <= (iflg_q & ~clr_mask) | det;
  end

  // Registered interrupt request from enabled pending flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(iflg_q & ien_q);
  end

  assign ien_rd  = ien_q;
  assign iflg_rd = iflg_q;
  assign edge_rd = edge_q;
`else
  assign ien_rd  = '0;
  assign iflg_rd = '0;
  assign edge_rd = '0;
  assign irq     = 1'b0;
`endif

  // Read mux; bits at and above WIDTH read as zero.
  always_comb begin
    rd_w = '0;
    case (rs)
      RS_DATA: rd_w = (gpio_o & gpio_oe) | (sync & ~gpio_oe);
      RS_DIR:  rd_w = gpio_oe;
      RS_IEN:  rd_w = ien_rd;
      RS_IFLG: rd_w = iflg_rd;
      RS_EDGE: rd_w = edge_rd;
      default: rd_w = '0;
    endcase
    rd_byte = 8'h00;
    rd_byte[WIDTH-1:0] = rd_w;
  end

  // Read data is registered every cycle from rs, independent of cs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dout <= 8'h00;
    else       dout <= rd_byte;
  end

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed scoreboard bench for gpio_port (WIDTH=8,
// SYNC_STAGES=2). Interrupt checks follow the GPIO_IRQ_EN build macro.
module tb_gpio_port;

  localparam int WIDTH  = 8;
  localparam int SYNC   = 2;
  localparam int K_DOUT = 0;
  localparam int K_O    = 1;
  localparam int K_OE   = 2;
  localparam int K_IRQ  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [2:0] rs = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [WIDTH-1:0] gpio_i = '0;
  logic [WIDTH-1:0] gpio_o;
  logic [WIDTH-1:0] gpio_oe;
  logic       irq;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    int         due;
    string      name;
  } ent_t;

  ent_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  gpio_port #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .rs(rs), .din(din),
    .dout(dout), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe),
    .irq(irq)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to schedule expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [7:0] observe(input int kind);
    case (kind)
      K_DOUT:  observe = dout;
      K_O:     observe = gpio_o;
      K_OE:    observe = gpio_oe;
      default: observe = {7'd0, irq};
    endcase
  endfunction

  task automatic check_output(input ent_t e);
    logic [7:0] act;
    act = observe(e.kind);
    total++;
    if (act !== e.exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", e.name, act, e.exp, cyc);
    end
  endtask

  // Monitor: compare every expectation that falls due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        check_output(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic push_exp(input int kind, input logic [7:0] exp, input int delay, input string name);
    ent_t e;
    e.kind = kind;
    e.exp  = exp;
    e.due  = cyc + delay;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic c, input logic w, input logic [2:0] r, input logic [7:0] d);
    step();
    cs  = c;
    we  = w;
    rs  = r;
    din = d;
  endtask

  task automatic wr(input logic [2:0] r, input logic [7:0] d);
    apply_stimulus(1'b1, 1'b1, r, d);
  endtask

  task automatic rd(input logic [2:0] r, input logic [7:0] exp, input string name);
    apply_stimulus(1'b1, 1'b0, r, 8'h00);
    push_exp(K_DOUT, exp, 1, name);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    // Reset state.
    step();
    step();
    push_exp(K_O, 8'h00, 0, "rst_gpio_o");
    push_exp(K_OE, 8'h00, 0, "rst_gpio_oe");
    push_exp(K_IRQ, 8'h00, 0, "rst_irq");
    push_exp(K_DOUT, 8'h00, 0, "rst_dout");
    step();
    reset = 1'b0;

    // Direction, data load and readback.
    wr(3'd1, 8'hFF); push_exp(K_OE, 8'hFF, 1, "dir_oe_ff");
    wr(3'd0, 8'hA5); push_exp(K_O, 8'hA5, 1, "data_a5");
    rd(3'd0, 8'hA5, "rd_data_a5");
    rd(3'd1, 8'hFF, "rd_dir_ff");

    // Atomic set/clear/toggle; those registers read 0.
    wr(3'd5, 8'h0F); push_exp(K_O, 8'hAF, 1, "set_0f");
    wr(3'd6, 8'h81); push_exp(K_O, 8'h2E, 1, "clr_81");
    wr(3'd7, 8'hFF); push_exp(K_O, 8'hD1, 1, "tgl_ff");
    rd(3'd5, 8'h00, "rd_set_zero");
    rd(3'd6, 8'h00, "rd_clr_zero");
    rd(3'd7, 8'h00, "rd_tgl_zero");

    // Mixed direction read and an ignored write with cs=0.
    wr(3'd1, 8'h0F); push_exp(K_OE, 8'h0F, 1, "dir_0f");
    wr(3'd0, 8'h05); push_exp(K_O, 8'h05, 1, "data_05");
    gpio_i = 8'hC0;
    idle(SYNC + 1);
    rd(3'd0, 8'hC5, "rd_mixed_c5");
    apply_stimulus(1'b0, 1'b1, 3'd0, 8'hFF); push_exp(K_O, 8'h05, 1, "cs0_ignored");

`ifdef GPIO_IRQ_EN
    // Flags from the rising inputs on bits 6 and 7, then clear them.
    rd(3'd3, 8'hC0, "rd_iflg_c0");
    idle(1);
    gpio_i = 8'h00;
    idle(4);
    wr(3'd3, 8'hFF);
    idle(1);
    rd(3'd3, 8'h00, "iflg_cleared");
    wr(3'd1, 8'h00);
    wr(3'd4, 8'h00);
    wr(3'd2, 8'h01); push_exp(K_IRQ, 8'h00, 1, "irq_idle");

    // Rising edge on bit 0: flag after SYNC+1 edges, irq one later.
    idle(1);
    gpio_i = 8'h01;
    push_exp(K_IRQ, 8'h00, SYNC + 1, "irq_not_yet");
    push_exp(K_IRQ, 8'h01, SYNC + 2, "irq_rise0");
    idle(SYNC + 1);
    rd(3'd3, 8'h01, "rd_iflg_01");
    rd(3'd2, 8'h01, "rd_ien_01");
    wr(3'd3, 8'h01);
    push_exp(K_IRQ, 8'h01, 1, "irq_hold_on_clr_edge");
    push_exp(K_IRQ, 8'h00, 2, "irq_cleared");

    // Falling polarity on bit 1: a rise sets nothing.
    wr(3'd4, 8'h02);
    idle(1);
    gpio_i = 8'h03;
    idle(4);
    rd(3'd3, 8'h00, "rise_on_falling_bit");

    // Falling edge coincides with a clear of the same flag: set wins.
    idle(1);
    gpio_i = 8'h01;
    idle(1);
    wr(3'd3, 8'h02);
    idle(1);
    rd(3'd3, 8'h02, "set_wins");
    push_exp(K_IRQ, 8'h00, 1, "irq_masked_bit1");

    // Output-direction bits never flag; EDGE change alone never flags.
    wr(3'd1, 8'h04);
    idle(1);
    gpio_i = 8'h05;
    idle(4);
    rd(3'd3, 8'h02, "dir_out_no_flag");
    wr(3'd4, 8'h00);
    idle(3);
    rd(3'd3, 8'h02, "edge_change_no_flag");
`else
    // Interrupt registers absent: they read 0, ignore writes, irq low.
    wr(3'd2, 8'hFF);
    wr(3'd4, 8'hFF);
    wr(3'd1, 8'h00);
    idle(1);
    gpio_i = 8'h00;
    idle(4);
    gpio_i = 8'h05;
    idle(SYNC + 1);
    push_exp(K_IRQ, 8'h00, 1, "irq_tied_low");
    rd(3'd2, 8'h00, "rd_ien_absent");
    rd(3'd3, 8'h00, "rd_iflg_absent");
    rd(3'd4, 8'h00, "rd_edge_absent");
    wr(3'd1, 8'h04);
`endif

    // Asynchronous reset in the middle of a write.
    step();
    cs = 1'b1; we = 1'b1; rs = 3'd1; din = 8'hFF;
    #2;
    reset = 1'b1;
    push_exp(K_O, 8'h00, 0, "midrst_gpio_o");
    push_exp(K_OE, 8'h00, 0, "midrst_gpio_oe");
    push_exp(K_IRQ, 8'h00, 0, "midrst_irq");
    push_exp(K_DOUT, 8'h00, 0, "midrst_dout");
    step();
    cs = 1'b0; we = 1'b0; rs = 3'd0; din = 8'h00;
    step();
    reset = 1'b0;
    rd(3'd1, 8'h00, "dir_after_rst");
    rd(3'd3, 8'h00, "iflg_after_rst");
    idle(3);
`ifdef GPIO_IRQ_EN
    // Pins held high across reset release raise rising-edge flags.
    rd(3'd3, 8'h05, "iflg_high_across_rst");
`else
    rd(3'd3, 8'h00, "iflg_absent_after_rst");
`endif
    push_exp(K_IRQ, 8'h00, 1, "irq_after_rst");
    idle(3);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
